// File: rtl/hazard_scoreboard_if.sv
// ============================================================================
// hazard_scoreboard_if : ID-stage request and hazard-control bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic             ex_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_reg_write, id_mem_read, flush,
    input  stall, ex_bubble, fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_reg_write, id_mem_read, flush,
    output stall, ex_bubble, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : load-use stall and registered ALU forwarding selects
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  hazard_scoreboard_if.slave bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The WB producer is never forwarded (register file writes before it is
  // read), so only the EX and MEM shadow entries influence any output.
  logic             ex_v_q, ex_rw_q, ex_mr_q;
  logic [REG_W-1:0] ex_dest_q;
  logic             mem_v_q, mem_rw_q;
  logic [REG_W-1:0] mem_dest_q;

  logic             ex_v_d, ex_rw_d, ex_mr_d;
  logic [REG_W-1:0] ex_dest_d;
  logic             ex_bubble_q, ex_bubble_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic stall_w, advance_w;

  function automatic logic hit(input logic v, input logic rw,
                               input logic [REG_W-1:0] d,
                               input logic [REG_W-1:0] r);
    return v & rw & (d == r) & (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic uses,
                                         input logic [REG_W-1:0] r,
                                         input logic ev, input logic erw,
                                         input logic [REG_W-1:0] ed,
                                         input logic mv, input logic mrw,
                                         input logic [REG_W-1:0] md);
    if (uses && hit(ev, erw, ed, r))      return SEL_EXM;
    else if (uses && hit(mv, mrw, md, r)) return SEL_MWB;
    else                                  return SEL_RF;
  endfunction

  always_comb begin
    stall_w = bus.id_valid & ~bus.flush & ex_mr_q & ex_v_q &
              ((bus.id_uses_rs & (ex_dest_q == bus.id_rs) & (bus.id_rs != '0)) |
               (bus.id_uses_rt & (ex_dest_q == bus.id_rt) & (bus.id_rt != '0)));
    advance_w = bus.id_valid & ~stall_w & ~bus.flush;
  end

  always_comb begin
    ex_v_d        = 1'b0;
    ex_rw_d       = 1'b0;
    ex_mr_d       = 1'b0;
    ex_dest_d     = ex_dest_q;
    ex_bubble_d   = 1'b1;
    fwd_a_d       = SEL_RF;
    fwd_b_d       = SEL_RF;
    stall_count_d = stall_count_q;

    if (advance_w) begin
      ex_v_d      = 1'b1;
      ex_rw_d     = bus.id_reg_write;
      ex_mr_d     = bus.id_mem_read;
      ex_dest_d   = bus.id_dest;
      ex_bubble_d = 1'b0;
      fwd_a_d     = fwd_sel(bus.id_uses_rs, bus.id_rs, ex_v_q, ex_rw_q, ex_dest_q,
                            mem_v_q, mem_rw_q, mem_dest_q);
      fwd_b_d     = fwd_sel(bus.id_uses_rt, bus.id_rt, ex_v_q, ex_rw_q, ex_dest_q,
                            mem_v_q, mem_rw_q, mem_dest_q);
    end

    if (stall_w && (stall_count_q != CNT_MAX))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_q        <= 1'b0;
      ex_rw_q       <= 1'b0;
      ex_mr_q       <= 1'b0;
      ex_dest_q     <= '0;
      mem_v_q       <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_dest_q    <= '0;
      ex_bubble_q   <= 1'b1;
      fwd_a_q       <= SEL_RF;
      fwd_b_q       <= SEL_RF;
      stall_count_q <= '0;
    end else begin
      mem_v_q       <= ex_v_q;
      mem_rw_q      <= ex_rw_q;
      mem_dest_q    <= ex_dest_q;
      ex_v_q        <= ex_v_d;
      ex_rw_q       <= ex_rw_d;
      ex_mr_q       <= ex_mr_d;
      ex_dest_q     <= ex_dest_d;
      ex_bubble_q   <= ex_bubble_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall       = stall_w;
  assign bus.ex_bubble   = ex_bubble_q;
  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard : directed vector bench for hazard_scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_scoreboard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       st;
    logic       bub;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input int rs, input int rt,
                              input logic urs, input logic urt, input int dest,
                              input logic rw, input logic mr, input logic fl,
                              input logic st, input logic bub, input int fa,
                              input int fb, input int cnt);
    vec_t t;
    t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt;
    t.dest = 5'(dest); t.rw = rw; t.mr = mr; t.fl = fl;
    t.st = st; t.bub = bub; t.fa = 2'(fa); t.fb = 2'(fb); t.cnt = 4'(cnt);
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.id_valid     = t.v;
    bus.id_rs        = t.rs;
    bus.id_rt        = t.rt;
    bus.id_uses_rs   = t.urs;
    bus.id_uses_rt   = t.urt;
    bus.id_dest      = t.dest;
    bus.id_reg_write = t.rw;
    bus.id_mem_read  = t.mr;
    bus.flush        = t.fl;
  endtask

  // One pipeline cycle: stall checked mid-cycle, registered outputs after the edge.
  task automatic run_vec(input vec_t t, input string tag);
    @(negedge clk);
    drive(t);
    #1;
    chk({tag, ".stall"}, int'(bus.stall), int'(t.st));
    @(posedge clk);
    #1;
    chk({tag, ".ex_bubble"}, int'(bus.ex_bubble), int'(t.bub));
    chk({tag, ".fwd_a"}, int'(bus.fwd_a_sel), int'(t.fa));
    chk({tag, ".fwd_b"}, int'(bus.fwd_b_sel), int'(t.fb));
    chk({tag, ".count"}, int'(bus.stall_count), int'(t.cnt));
  endtask

  vec_t vecs [20];

  initial begin
    checks   = 0;
    failures = 0;
    //                v  rs rt urs urt dst rw mr fl   st bub fa fb cnt
    vecs[0]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 1, 0, 0, 0);  // idle
    vecs[1]  = mk(1,  1, 2, 1, 1,  8, 1, 0, 0,   0, 0, 0, 0, 0);  // add $8
    vecs[2]  = mk(1,  8, 9, 1, 1, 10, 1, 0, 0,   0, 0, 1, 0, 0);  // sub rs=$8
    vecs[3]  = mk(1,  8, 0, 1, 1, 11, 1, 0, 0,   0, 0, 2, 0, 0);  // reads $8 one slot later
    vecs[4]  = mk(1,  2, 0, 1, 0,  5, 1, 1, 0,   0, 0, 0, 0, 0);  // lw $5
    vecs[5]  = mk(1,  3, 5, 1, 1,  6, 1, 0, 0,   1, 1, 0, 0, 1);  // load-use stall
    vecs[6]  = mk(1,  3, 5, 1, 1,  6, 1, 0, 0,   0, 0, 0, 2, 1);  // add advances
    vecs[7]  = mk(1,  0, 0, 0, 0,  0, 1, 1, 0,   0, 0, 0, 0, 1);  // lw $0
    vecs[8]  = mk(1,  0, 0, 1, 1, 12, 1, 0, 0,   0, 0, 0, 0, 1);  // reads $0
    vecs[9]  = mk(1,  0, 0, 0, 0,  7, 1, 0, 0,   0, 0, 0, 0, 1);  // writer $7
    vecs[10] = mk(1,  0, 0, 0, 0,  7, 1, 0, 0,   0, 0, 0, 0, 1);  // writer $7
    vecs[11] = mk(1,  7, 0, 1, 0, 13, 1, 0, 0,   0, 0, 1, 0, 1);  // newest wins
    vecs[12] = mk(1,  2, 0, 0, 0,  5, 1, 1, 0,   0, 0, 0, 0, 1);  // lw $5
    vecs[13] = mk(1,  3, 5, 1, 1,  6, 1, 0, 1,   0, 1, 0, 0, 1);  // flush beats stall
    vecs[14] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 1, 0, 0, 1);  // idle
    vecs[15] = mk(1,  0, 0, 0, 0,  4, 1, 1, 0,   0, 0, 0, 0, 1);  // lw $4
    vecs[16] = mk(1,  1, 0, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 1);  // unrelated
    vecs[17] = mk(1,  4, 4, 1, 1, 15, 1, 0, 0,   0, 0, 2, 2, 1);  // two behind load
    vecs[18] = mk(1,  2,15, 1, 1, 16, 1, 0, 0,   0, 0, 0, 1, 1);  // operand B EX fwd
    vecs[19] = mk(1, 15,15, 0, 0, 17, 1, 0, 0,   0, 0, 0, 0, 1);  // unused sources

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk("reset.stall", int'(bus.stall), 0);
    chk("reset.ex_bubble", int'(bus.ex_bubble), 1);
    chk("reset.fwd_a", int'(bus.fwd_a_sel), 0);
    chk("reset.fwd_b", int'(bus.fwd_b_sel), 0);
    chk("reset.count", int'(bus.stall_count), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while a load-use stall is active.
    run_vec(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1), "rstmid.lw");
    @(negedge clk);
    drive(mk(1, 3, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rstmid.stall_before", int'(bus.stall), 1);
    rst = 1'b1;
    #1;
    chk("rstmid.stall_in_reset", int'(bus.stall), 0);
    chk("rstmid.ex_bubble", int'(bus.ex_bubble), 1);
    chk("rstmid.count", int'(bus.stall_count), 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(1, 3, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0), "rstmid.first");

    // Saturation of the 4-bit stall counter: 16 separate load-use stalls.
    for (int i = 1; i <= 16; i++) begin
      int prev;
      int now;
      prev = (i - 1 > 15) ? 15 : i - 1;
      now  = (i > 15) ? 15 : i;
      run_vec(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, prev), $sformatf("sat%0d.lw", i));
      run_vec(mk(1, 3, 5, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0, now),  $sformatf("sat%0d.stall", i));
      run_vec(mk(1, 3, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 2, now),  $sformatf("sat%0d.adv", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
